hazard_stall_ctrl: RTL and testbench

- Hazard-detection and stall controller for the 5-stage MIPS pipeline.
- Produces the `stall` input consumed by the forwarding/pipeline-register block. That input inserts a bubble into ID/EX while PC and IF/ID hold.
- Detects the data hazards that forwarding cannot cover: load-use, branch-use of not-yet-available results, and HI/LO access while the multi-cycle multiply/divide unit is busy.
- Owns the mul/div busy sequencer and handles exception flush.

---
 rtl/hazard_stall_ctrl.sv | 143 ++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
// Hazard detection and stall control for the 5-stage MIPS pipeline.
// Raises a bubble into ID/EX (holding PC and IF/ID) for the hazards forwarding
// cannot cover: load-use, branch operands not yet available in ID, and HI/LO
// access while the multi-cycle mul/div unit is busy. Also owns the mul/div busy
// sequencer, the exception flush and a saturating stall-cycle counter.
//
// Ports
//   clk, rst            pipeline clock, asynchronous active-high reset
//   id_*                ID-stage operand fields and instruction class flags
//   exe_*               EXE-stage load/write/destination and mul/div start
//   mem_load, mem_wdest MEM-stage load destination
//   exc_flush           exception/eret commit
//   stall, pc_we, ifid_we, flush   pipeline control
//   md_busy, md_done    mul/div unit occupancy and final busy cycle
//   stall_cnt           saturating count of stall cycles
//
// state | meaning
// IDLE  | mul/div unit free
// MUL   | multiply in flight, cnt = remaining cycles - 1
// DIV   | divide in flight, cnt = remaining cycles - 1
module hazard_stall_ctrl #(
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 33,
   parameter int CNT_W   = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_use_rs,
   input  logic        id_use_rt,
   input  logic        id_branch,
   input  logic        id_hilo,
   input  logic        exe_load,
   input  logic        exe_rf_wen,
   input  logic [4:0]  exe_wdest,
   input  logic        exe_mul,
   input  logic        exe_div,
   input  logic        mem_load,
   input  logic [4:0]  mem_wdest,
   input  logic        exc_flush,
   output logic        stall,
   output logic        pc_we,
   output logic        ifid_we,
   output logic        flush,
   output logic        md_busy,
   output logic        md_done,
   output logic [15:0] stall_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2
   } md_state_t;

   md_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [15:0]      stall_cnt_q, stall_cnt_d;

   logic exe_hit_rs, exe_hit_rt, mem_hit_rs, mem_hit_rt;
   logic load_use, br_exe, br_mem, md_hz;
   logic md_last;

   // Register 0 is hardwired, so a write to it never creates a dependency.
   assign exe_hit_rs = (exe_wdest != 5'd0) && (id_rs == exe_wdest);
   assign exe_hit_rt = (exe_wdest != 5'd0) && (id_rt == exe_wdest);
   assign mem_hit_rs = (mem_wdest != 5'd0) && (id_rs == mem_wdest);
   assign mem_hit_rt = (mem_wdest != 5'd0) && (id_rt == mem_wdest);

   assign md_last = (state_q != IDLE) && (cnt_q == '0);

   always_comb begin
      load_use = exe_load && exe_rf_wen &&
                 (((id_use_rs || id_branch) && exe_hit_rs) || (id_use_rt && exe_hit_rt));
      br_exe   = id_branch && exe_rf_wen && (exe_hit_rs || (id_use_rt && exe_hit_rt));
      br_mem   = id_branch && mem_load && (mem_hit_rs || (id_use_rt && mem_hit_rt));
      // On the last busy cycle HI/LO is written at the edge, so a reader can proceed.
      md_hz    = id_hilo && (((state_q != IDLE) && !md_last) || exe_mul || exe_div);
   end

   always_comb begin
      flush   = exc_flush;
      stall   = 1'b0;
      pc_we   = 1'b1;
      ifid_we = 1'b1;
      if (exc_flush) begin
         ifid_we = 1'b0;
      end else begin
         stall   = md_hz | load_use | br_exe | br_mem;
         pc_we   = !stall;
         ifid_we = !stall;
      end
   end

   assign md_busy   = (state_q != IDLE);
   // An aborted operation never reports completion.
   assign md_done   = md_last && !exc_flush;
   assign stall_cnt = stall_cnt_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (exc_flush) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else if (state_q == IDLE) begin
         // Divide wins if both start strobes arrive together.
         if (exe_div) begin
            state_d = DIV;
            cnt_d   = CNT_W'(DIV_LAT - 1);
         end else if (exe_mul) begin
            state_d = MUL;
            cnt_d   = CNT_W'(MUL_LAT - 1);
         end
      end else if (cnt_q == '0) begin
         state_d = IDLE;
      end else begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         stall_cnt_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

   localparam int MUL_LAT = 4;
   localparam int DIV_LAT = 33;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  id_rs = '0, id_rt = '0, exe_wdest = '0, mem_wdest = '0;
   logic        id_use_rs = 0, id_use_rt = 0, id_branch = 0, id_hilo = 0;
   logic        exe_load = 0, exe_rf_wen = 0, exe_mul = 0, exe_div = 0;
   logic        mem_load = 0, exc_flush = 0;
   logic        stall, pc_we, ifid_we, flush, md_busy, md_done;
   logic [15:0] stall_cnt;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: cycles left on the mul/div unit and total stall cycles.
   int md_left = 0;
   int scnt    = 0;
   bit e_stall, e_pc_we, e_ifid_we, e_flush, e_busy, e_done;

   hazard_stall_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)) dut (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .id_branch(id_branch), .id_hilo(id_hilo),
      .exe_load(exe_load), .exe_rf_wen(exe_rf_wen), .exe_wdest(exe_wdest),
      .exe_mul(exe_mul), .exe_div(exe_div),
      .mem_load(mem_load), .mem_wdest(mem_wdest), .exc_flush(exc_flush),
      .stall(stall), .pc_we(pc_we), .ifid_we(ifid_we), .flush(flush),
      .md_busy(md_busy), .md_done(md_done), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit dep(input logic [4:0] d, input bit rs_used, input bit rt_used);
      return (d != 0) && ((rs_used && id_rs == d) || (rt_used && id_rt == d));
   endfunction

   task automatic model_eval();
      bit lu, be, bm, mh;
      lu = exe_load && exe_rf_wen && dep(exe_wdest, id_use_rs || id_branch, id_use_rt);
      be = id_branch && exe_rf_wen && dep(exe_wdest, 1'b1, id_use_rt);
      bm = id_branch && mem_load && dep(mem_wdest, 1'b1, id_use_rt);
      mh = id_hilo && (md_left > 1 || exe_mul || exe_div);
      e_flush   = exc_flush;
      e_stall   = !exc_flush && (lu || be || bm || mh);
      e_pc_we   = exc_flush ? 1'b1 : !e_stall;
      e_ifid_we = exc_flush ? 1'b0 : !e_stall;
      e_busy    = md_left > 0;
      e_done    = md_left == 1 && !exc_flush;
   endtask

   task automatic check_all();
      model_eval();
      chk("stall", 32'(stall), 32'(e_stall));
      chk("pc_we", 32'(pc_we), 32'(e_pc_we));
      chk("ifid_we", 32'(ifid_we), 32'(e_ifid_we));
      chk("flush", 32'(flush), 32'(e_flush));
      chk("md_busy", 32'(md_busy), 32'(e_busy));
      chk("md_done", 32'(md_done), 32'(e_done));
      chk("stall_cnt", 32'(stall_cnt), 32'(scnt));
   endtask

   task automatic model_update();
      if (rst) begin
         md_left = 0;
         scnt    = 0;
      end else begin
         if (e_stall && scnt < 65535) scnt++;
         if (exc_flush) md_left = 0;
         else if (md_left > 0) md_left--;
         else if (exe_div) md_left = DIV_LAT;
         else if (exe_mul) md_left = MUL_LAT;
      end
   endtask

   // Inputs are set just after a falling edge; checks land 1 time unit later.
   task automatic tick();
      #1;
      check_all();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; id_branch = 0; id_hilo = 0;
      exe_load = 0; exe_rf_wen = 0; exe_wdest = 0; exe_mul = 0; exe_div = 0;
      mem_load = 0; mem_wdest = 0; exc_flush = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      md_left = 0;
      scnt = 0;
      tick();
      rst = 1'b0;
   endtask

   int busy_n, done_n, stall_n;

   initial begin
      @(negedge clk);
      do_reset();
      tick();
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_pc_we", 32'(pc_we), 32'd1);
      chk("rst_busy", 32'(md_busy), 32'd0);
      chk("rst_scnt", 32'(stall_cnt), 32'd0);

      // Load-use, then the same with destination r0.
      exe_load = 1; exe_rf_wen = 1; exe_wdest = 8; id_rs = 8; id_use_rs = 1;
      #1;
      chk("lu_stall", 32'(stall), 32'd1);
      chk("lu_pc_we", 32'(pc_we), 32'd0);
      tick();
      exe_load = 0; exe_rf_wen = 0; exe_wdest = 0;
      tick();
      chk("lu_one_cycle", 32'(stall_cnt), 32'd1);
      exe_load = 1; exe_rf_wen = 1; exe_wdest = 0; id_rs = 0;
      #1;
      chk("lu_r0", 32'(stall), 32'd0);
      tick();

      // Load r5 followed by beq r5: two stall cycles.
      do_reset();
      idle_inputs();
      id_branch = 1; id_rs = 5; id_rt = 7; id_use_rt = 1;
      exe_load = 1; exe_rf_wen = 1; exe_wdest = 5;
      tick();
      exe_load = 0; exe_rf_wen = 0; exe_wdest = 0; mem_load = 1; mem_wdest = 5;
      #1;
      chk("br_mem_stall", 32'(stall), 32'd1);
      tick();
      mem_load = 0; mem_wdest = 0;
      #1;
      chk("br_resolved", 32'(stall), 32'd0);
      tick();
      chk("lb_scnt", 32'(stall_cnt), 32'd2);

      // Divide then mflo held; multiply variant.
      for (int v = 0; v < 2; v++) begin
         do_reset();
         idle_inputs();
         if (v == 0) exe_div = 1; else exe_mul = 1;
         tick();
         idle_inputs();
         id_hilo = 1;
         busy_n = 0; done_n = 0; stall_n = 0;
         for (int c = 0; c < DIV_LAT + 3; c++) begin
            #1;
            busy_n  += int'(md_busy);
            done_n  += int'(md_done);
            stall_n += int'(stall);
            if (md_done) chk("done_no_stall", 32'(stall), 32'd0);
            tick();
         end
         chk(v == 0 ? "div_busy_len" : "mul_busy_len", 32'(busy_n), v == 0 ? 32'(DIV_LAT) : 32'(MUL_LAT));
         chk("md_done_count", 32'(done_n), 32'd1);
         chk("md_stall_len", 32'(stall_n), v == 0 ? 32'(DIV_LAT - 1) : 32'(MUL_LAT - 1));
      end

      // Flush while a divide has 11 cycles left.
      do_reset();
      idle_inputs();
      exe_div = 1;
      tick();
      exe_div = 0;
      id_hilo = 1;
      for (int c = 0; c < 100 && md_left != 11; c++) tick();
      chk("flush_reached", 32'(md_left), 32'd11);
      exc_flush = 1;
      #1;
      chk("flush_out", 32'(flush), 32'd1);
      chk("flush_stall", 32'(stall), 32'd0);
      chk("flush_ifid", 32'(ifid_we), 32'd0);
      tick();
      exc_flush = 0;
      done_n = 0;
      #1;
      chk("flush_busy", 32'(md_busy), 32'd0);
      for (int c = 0; c < 15; c++) begin
         #1;
         done_n += int'(md_done);
         tick();
      end
      chk("flush_no_done", 32'(done_n), 32'd0);

      // Asynchronous reset in the middle of a divide.
      idle_inputs();
      exe_div = 1;
      tick();
      exe_div = 0;
      tick();
      tick();
      #2;
      rst = 1'b1;
      md_left = 0;
      scnt = 0;
      #1;
      chk("arst_busy", 32'(md_busy), 32'd0);
      chk("arst_scnt", 32'(stall_cnt), 32'd0);
      chk("arst_pc_we", 32'(pc_we), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // Randomized traffic on a small register set to get frequent matches.
      for (int c = 0; c < 3000; c++) begin
         id_rs      = 5'($urandom_range(0, 3));
         id_rt      = 5'($urandom_range(0, 3));
         id_use_rs  = 1'($urandom);
         id_use_rt  = 1'($urandom);
         id_branch  = ($urandom_range(0, 3) == 0);
         id_hilo    = ($urandom_range(0, 2) == 0);
         exe_load   = 1'($urandom);
         exe_rf_wen = 1'($urandom);
         exe_wdest  = 5'($urandom_range(0, 3));
         mem_load   = 1'($urandom);
         mem_wdest  = 5'($urandom_range(0, 3));
         exe_mul    = (md_left == 0) && ($urandom_range(0, 7) == 0);
         exe_div    = (md_left == 0) && ($urandom_range(0, 15) == 0);
         exc_flush  = ($urandom_range(0, 40) == 0);
         tick();
      end

      // Continuous stall to drive the counter into saturation.
      do_reset();
      idle_inputs();
      exe_load = 1; exe_rf_wen = 1; exe_wdest = 9; id_rt = 9; id_use_rt = 1;
      for (int c = 0; c < 70000; c++) tick();
      chk("scnt_sat", 32'(stall_cnt), 32'hFFFF);
      idle_inputs();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
